// File: rtl/canvas_write_ctrl.sv
// canvas_write_ctrl: arbitrates buffered brush writes and a raster-order clear engine onto the pixel store write port.
// Optional BRUSH_BOUNDS_CHECK_EN drops out-of-canvas brush entries and flags them on oob_err.
module canvas_write_ctrl #(
    parameter int GRID_W     = 8,
    parameter int GRID_H     = 8,
    parameter int COORD_W    = 8,
    parameter int COLOR_W    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              brush_valid,
    output logic                              brush_ready,
    input  logic [COORD_W-1:0]                brush_x,
    input  logic [COORD_W-1:0]                brush_y,
    input  logic [COLOR_W-1:0]                brush_color,
    input  logic                              clear_req,
    input  logic [COLOR_W-1:0]                clear_color,
    output logic                              busy,
    output logic                              clear_done,
    output logic                              we,
    output logic [COORD_W-1:0]                wx,
    output logic [COORD_W-1:0]                wy,
    output logic [COLOR_W-1:0]                wdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
`ifdef BRUSH_BOUNDS_CHECK_EN
    ,
    output logic                              oob_err
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = 2*COORD_W + COLOR_W;

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [COORD_W-1:0] hx, hy, cx, cy;
    logic [COLOR_W-1:0] hc, ccol;
    logic               push, pop, oob, x_last, y_last;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == FIFO_DEPTH-1) ? '0 : p + 1'b1;
    endfunction

    assign brush_ready = int'(fifo_count) != FIFO_DEPTH;
    assign push        = brush_valid && brush_ready;
    // A clear request in IDLE takes priority over draining the FIFO.
    assign pop         = state == IDLE && !clear_req && fifo_count != '0;
    assign {hx, hy, hc} = mem[rd_ptr];
    assign x_last      = int'(cx) == GRID_W-1;
    assign y_last      = int'(cy) == GRID_H-1;
`ifdef BRUSH_BOUNDS_CHECK_EN
    assign oob = int'(hx) >= GRID_W || int'(hy) >= GRID_H;
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {brush_x, brush_y, brush_color};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cx         <= '0;
            cy         <= '0;
            ccol       <= '0;
            we         <= 1'b0;
            wx         <= '0;
            wy         <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
`ifdef BRUSH_BOUNDS_CHECK_EN
            oob_err    <= 1'b0;
`endif
        end else begin
            clear_done <= 1'b0;
`ifdef BRUSH_BOUNDS_CHECK_EN
            oob_err    <= 1'b0;
`endif
            if (state == CLEAR) begin
                we    <= 1'b1;
                wx    <= cx;
                wy    <= cy;
                wdata <= ccol;
                busy  <= 1'b1;
                cx    <= x_last ? '0 : cx + 1'b1;
                if (x_last)
                    cy <= y_last ? '0 : cy + 1'b1;
                if (x_last && y_last) begin
                    clear_done <= 1'b1;
                    state      <= IDLE;
                end
            end else begin
                busy <= 1'b0;
                if (clear_req) begin
                    state <= CLEAR;
                    cx    <= '0;
                    cy    <= '0;
                    ccol  <= clear_color;
                    we    <= 1'b0;
                end else if (pop) begin
                    we    <= !oob;
                    wx    <= hx;
                    wy    <= hy;
                    wdata <= hc;
`ifdef BRUSH_BOUNDS_CHECK_EN
                    oob_err <= oob;
`endif
                end else begin
                    we <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_canvas_write_ctrl.sv
// tb_canvas_write_ctrl: scoreboard bench; brush writes and clear fills are predicted as queues and matched by a monitor.
module tb_canvas_write_ctrl;
    localparam int GW = 8, GH = 8;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       brush_valid = 1'b0, brush_ready, clear_req = 1'b0;
    logic [7:0] brush_x = '0, brush_y = '0, wx, wy;
    logic [2:0] brush_color = '0, clear_color = '0, wdata;
    logic       busy, clear_done, we;
    logic [2:0] fifo_count;
`ifdef BRUSH_BOUNDS_CHECK_EN
    logic       oob_err;
`endif

    canvas_write_ctrl dut (
        .clk(clk), .reset_n(reset_n), .brush_valid(brush_valid), .brush_ready(brush_ready),
        .brush_x(brush_x), .brush_y(brush_y), .brush_color(brush_color),
        .clear_req(clear_req), .clear_color(clear_color), .busy(busy), .clear_done(clear_done),
        .we(we), .wx(wx), .wy(wy), .wdata(wdata), .fifo_count(fifo_count)
`ifdef BRUSH_BOUNDS_CHECK_EN
        , .oob_err(oob_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] x; logic [7:0] y; logic [2:0] c; logic d;} wr_t;
    wr_t bq[$], cq[$];
    wr_t got_w, exp_w;
    int checks = 0, errors = 0, clear_writes = 0, done_seen = 0, oob_seen = 0, oob_exp = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(int x, int y, int c, bit d);
        wr_t e;
        e.x = x[7:0];
        e.y = y[7:0];
        e.c = c[2:0];
        e.d = d;
        return e;
    endfunction

    // Monitor: a busy write must be the next clear cell, otherwise the next accepted brush entry.
    always @(negedge clk) begin
        if (reset_n) begin
            if (we) begin
                got_w = {wx, wy, wdata, clear_done};
                if (busy ? cq.size() == 0 : bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h busy %0b expected none", got_w, busy);
                end else begin
                    exp_w = busy ? cq.pop_front() : bq.pop_front();
                    if (busy)
                        clear_writes++;
                    chk(busy ? "clear_write" : "brush_write", 32'(got_w), 32'(exp_w));
                end
            end else begin
                chk("done_without_write", 32'(clear_done), 0);
            end
            if (clear_done)
                done_seen++;
`ifdef BRUSH_BOUNDS_CHECK_EN
            if (oob_err)
                oob_seen++;
`endif
        end
    end

    task automatic accept(int x, int y, int c);
`ifdef BRUSH_BOUNDS_CHECK_EN
        if (x >= GW || y >= GH) begin
            oob_exp++;
            return;
        end
`endif
        bq.push_back(mk(x, y, c, 1'b0));
    endtask

    // Called at a negedge; returns at the negedge after the entry was accepted.
    task automatic push_entry(int x, int y, int c);
        brush_valid = 1'b1;
        brush_x     = x[7:0];
        brush_y     = y[7:0];
        brush_color = c[2:0];
        for (int i = 0; i < 300; i++) begin
            if (brush_ready) begin
                accept(x, y, c);
                @(negedge clk);
                brush_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        brush_valid = 1'b0;
        chk("push_timeout", 1, 0);
    endtask

    task automatic add_clear(int color);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                cq.push_back(mk(x, y, color, x == GW-1 && y == GH-1));
    endtask

    task automatic start_clear(int color, bit held);
        clear_req   = 1'b1;
        clear_color = color[2:0];
        add_clear(color);
        if (!held) begin
            @(negedge clk);
            clear_req = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (clear_done)
                return;
        end
        chk("clear_done_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (bq.size() != 0 || fifo_count != 0); i++)
            @(negedge clk);
        chk("drain_bq", bq.size(), 0);
    endtask

    initial begin
        int n, d0;
        repeat (2) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_wxy", {wx, wy, wdata}, 0);
        chk("rst_ready", brush_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        push_entry(3, 5, 6);
        chk("t1_count1", fifo_count, 1);
        chk("t1_ready1", brush_ready, 1);
        chk("t1_we0", we, 0);
        @(negedge clk);
        chk("t1_we", we, 1);
        chk("t1_wxyd", {wx, wy, 5'(wdata)}, {8'd3, 8'd5, 5'd6});
        chk("t1_count0", fifo_count, 0);
        chk("t1_ready", brush_ready, 1);

        start_clear(2, 1'b0);
        wait_done();
        chk("t2_last", {we, busy, wx, wy}, {1'b1, 1'b1, 8'd7, 8'd7});
        @(negedge clk);
        chk("t2_busy_off", {we, busy}, 0);
        chk("t2_cq_empty", cq.size(), 0);
        chk("t2_writes", clear_writes, 64);

        start_clear(5, 1'b0);
        fork
            for (int k = 0; k < 5; k++)
                push_entry(k + 1, 7 - k, k + 2);
            begin
                repeat (10) @(negedge clk);
                chk("t3_full_count", fifo_count, 4);
                chk("t3_full_ready", brush_ready, 0);
            end
            begin
                wait_done();
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t3_consecutive", {we, busy}, 2'b10);
                end
            end
        join
        drain();

        start_clear(1, 1'b0);
        push_entry(1, 1, 1);
        push_entry(2, 2, 2);
        n = 0;
        for (int i = 0; i < 100 && n < 20; i++) begin
            if (we && busy)
                n++;
            if (n < 20)
                @(negedge clk);
        end
        d0 = done_seen;
        reset_n = 1'b0;
        #1;
        chk("t4_we", we, 0);
        chk("t4_busy", busy, 0);
        chk("t4_count", fifo_count, 0);
        chk("t4_done", clear_done, 0);
        bq.delete();
        cq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t4_idle", {we, busy}, 0);
        end
        chk("t4_no_done", done_seen, d0);

        d0 = done_seen;
        start_clear(4, 1'b1);
        wait_done();
        add_clear(4);
        @(negedge clk);
        chk("t5_gap", {we, busy}, 0);
        wait_done();
        clear_req = 1'b0;
        @(negedge clk);
        chk("t5_idle", {we, busy}, 0);
        chk("t5_cq_empty", cq.size(), 0);
        chk("t5_dones", done_seen - d0, 2);

`ifdef BRUSH_BOUNDS_CHECK_EN
        push_entry(8, 2, 1);
        push_entry(7, 7, 3);
        chk("t6_oob_pulse", {oob_err, we}, 2'b10);
        @(negedge clk);
        chk("t6_write", {oob_err, we, wx, wy}, {1'b0, 1'b1, 8'd7, 8'd7});
`endif

        fork
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(2, 0) != 0) begin
`ifdef BRUSH_BOUNDS_CHECK_EN
                    push_entry($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(7, 0));
`else
                    push_entry($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(7, 0));
`endif
                end else begin
                    @(negedge clk);
                end
            end
            repeat (3) begin
                repeat ($urandom_range(80, 20)) @(negedge clk);
                start_clear($urandom_range(7, 0), 1'b0);
                wait_done();
            end
        join
        drain();
        repeat (3) @(negedge clk);
        chk("final_cq_empty", cq.size(), 0);
        chk("final_count", fifo_count, 0);
`ifdef BRUSH_BOUNDS_CHECK_EN
        chk("final_oob", oob_seen, oob_exp);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
